// File: rtl/analyzer_seq_trigger.sv
// Multi-stage sequential trigger for the logic analyzer: per-stage channel conditions,
// hit counts and inter-stage timeouts, producing a single registered trig pulse.
module analyzer_seq_trigger #(
  parameter int CH     = 8,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16,
  parameter int TO_W   = 16,
  localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CH-1:0]             digital_in,
  input  logic                      arm,
  input  logic                      trig_force,
  input  logic [SW-1:0]             last_stage,
  input  logic [2*STAGES-1:0]       stage_mode,
  input  logic [6*CH*STAGES-1:0]    stage_op,
  input  logic [CNT_W*STAGES-1:0]   stage_cnt,
  input  logic [TO_W-1:0]           seq_timeout,
  output logic                      trig,
  output logic                      armed,
  output logic                      triggered,
  output logic [SW-1:0]             cur_stage,
  output logic                      timeout_evt
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRIG} state_t;

  function automatic logic chan_eval(input logic [5:0] op, input logic q, input logic p);
    logic base;
    case (op[2:0])
      3'b000:  base = ~q;
      3'b001:  base = q;
      3'b010:  base = 1'b1;
      3'b011:  base = ~p & q;
      3'b100:  base = p & ~q;
      3'b101:  base = p ^ q;
      3'b110:  base = ~(p ^ q);
      default: base = 1'b0;
    endcase
    case (op[5:3])
      3'b000:  return base;
      3'b001:  return ~base;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic mode_combine(input logic [1:0] m, input logic [CH-1:0] r);
    case (m)
      2'b00:   return &r;
      2'b01:   return |r;
      2'b10:   return ~&r;
      default: return ~|r;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_hit(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TO_W-1:0] sat_inc_to(input logic [TO_W-1:0] v);
    return (&v) ? v : v + TO_W'(1);
  endfunction

  function automatic logic [SW-1:0] clamp_stage(input logic [SW-1:0] s);
    if ({{(32-SW){1'b0}}, s} > 32'(STAGES - 1)) return SW'(STAGES - 1);
    return s;
  endfunction

  state_t                    state, state_nx;
  logic [CH-1:0]             din_p0, din_p1;
  logic                      arm_q;
  logic [SW-1:0]             sh_last;
  logic [2*STAGES-1:0]       sh_mode;
  logic [6*CH*STAGES-1:0]    sh_op;
  logic [CNT_W*STAGES-1:0]   sh_cnt;
  logic [TO_W-1:0]           sh_to;
  logic [SW-1:0]             stage, stage_nx;
  logic [CNT_W-1:0]          hit, hit_nx, cur_cnt, req_cnt;
  logic [TO_W-1:0]           to_cnt, to_nx;
  logic [CH-1:0]             chan_res;
  logic [STAGES-1:0]         cond_vec;
  logic                      cond, advance, fire, to_fire, latch;
  logic                      fire_p0, to_evt_p0;

  always_comb begin
    cond_vec = '0;
    chan_res = '0;
    cond     = 1'b0;
    cur_cnt  = '0;
    for (int s = 0; s < STAGES; s++) begin
      for (int c = 0; c < CH; c++)
        chan_res[c] = chan_eval(sh_op[(s*CH+c)*6 +: 6], din_p0[c], din_p1[c]);
      cond_vec[s] = mode_combine(sh_mode[2*s +: 2], chan_res);
      if (stage == SW'(s)) begin
        cond    = cond_vec[s];
        cur_cnt = sh_cnt[s*CNT_W +: CNT_W];
      end
    end
    req_cnt = (cur_cnt == '0) ? CNT_W'(1) : cur_cnt;
    advance = cond && (({1'b0, hit} + (CNT_W+1)'(1)) >= {1'b0, req_cnt});
  end

  always_comb begin
    state_nx = state;
    stage_nx = stage;
    hit_nx   = hit;
    to_nx    = to_cnt;
    fire     = 1'b0;
    to_fire  = 1'b0;
    latch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm && !arm_q) begin
          state_nx = S_ARMED;
          latch    = 1'b1;
          stage_nx = '0;
          hit_nx   = '0;
          to_nx    = '0;
        end
      end
      S_ARMED: begin
        if (!arm) begin
          state_nx = S_IDLE;
          stage_nx = '0;
        end else if (trig_force) begin
          state_nx = S_TRIG;
          fire     = 1'b1;
        end else if (advance) begin
          if (stage == sh_last) begin
            state_nx = S_TRIG;
            fire     = 1'b1;
          end else begin
            stage_nx = stage + SW'(1);
            hit_nx   = '0;
            to_nx    = '0;
          end
        end else begin
          if (cond) hit_nx = sat_inc_hit(hit);
          if (stage != '0) begin
            if (sh_to != '0 && to_cnt == sh_to - TO_W'(1)) begin
              stage_nx = '0;
              hit_nx   = '0;
              to_nx    = '0;
              to_fire  = 1'b1;
            end else begin
              to_nx = sat_inc_to(to_cnt);
            end
          end
        end
      end
      S_TRIG: begin
        if (!arm) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage p0: input sampling, engine state and shadows; stage p1: registered output views.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      din_p0      <= '0;
      din_p1      <= '0;
      // Held high so an arm level present across reset does not count as a rising arm.
      arm_q       <= 1'b1;
      sh_last     <= '0;
      sh_mode     <= '0;
      sh_op       <= '0;
      sh_cnt      <= '0;
      sh_to       <= '0;
      stage       <= '0;
      hit         <= '0;
      to_cnt      <= '0;
      fire_p0     <= 1'b0;
      to_evt_p0   <= 1'b0;
      trig        <= 1'b0;
      timeout_evt <= 1'b0;
      armed       <= 1'b0;
      triggered   <= 1'b0;
      cur_stage   <= '0;
    end else begin
      state     <= state_nx;
      din_p0    <= digital_in;
      din_p1    <= din_p0;
      arm_q     <= arm;
      stage     <= stage_nx;
      hit       <= hit_nx;
      to_cnt    <= to_nx;
      fire_p0   <= fire;
      to_evt_p0 <= to_fire;
      if (latch) begin
        sh_last <= clamp_stage(last_stage);
        sh_mode <= stage_mode;
        sh_op   <= stage_op;
        sh_cnt  <= stage_cnt;
        sh_to   <= seq_timeout;
      end
      trig        <= fire_p0;
      timeout_evt <= to_evt_p0;
      armed       <= (state == S_ARMED);
      triggered   <= (state == S_TRIG);
      cur_stage   <= (state == S_IDLE) ? '0 : stage;
    end
  end

endmodule

// File: tb/tb_analyzer_seq_trigger.sv
// Bench for analyzer_seq_trigger: vector table, directed sequences and random stimulus
// checked against a rule-level reference model.
module tb_analyzer_seq_trigger;

  localparam int CH     = 8;
  localparam int STAGES = 4;
  localparam int CNT_W  = 16;
  localparam int TO_W   = 16;
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [CH-1:0]           digital_in;
  logic                    arm, trig_force;
  logic [SW-1:0]           last_stage;
  logic [2*STAGES-1:0]     stage_mode;
  logic [6*CH*STAGES-1:0]  stage_op;
  logic [CNT_W*STAGES-1:0] stage_cnt;
  logic [TO_W-1:0]         seq_timeout;
  logic                    trig, armed, triggered, timeout_evt;
  logic [SW-1:0]           cur_stage;

  analyzer_seq_trigger #(.CH(CH), .STAGES(STAGES), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk(clk), .rstn(rstn), .digital_in(digital_in), .arm(arm), .trig_force(trig_force),
    .last_stage(last_stage), .stage_mode(stage_mode), .stage_op(stage_op),
    .stage_cnt(stage_cnt), .seq_timeout(seq_timeout), .trig(trig), .armed(armed),
    .triggered(triggered), .cur_stage(cur_stage), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int trig_seen = 0;
  int to_seen = 0;

  // Reference model: 0 idle, 1 armed, 2 triggered
  int     m_state, m_stage, m_last, m_tov;
  longint m_hit, m_to;
  bit     m_armprev, p_fire, p_tf;
  bit [CH-1:0] m_dq, m_dp;
  int     m_op[STAGES][CH];
  int     m_mode[STAGES];
  longint m_cnt[STAGES];
  localparam longint HIT_MAX = (64'd1 << CNT_W) - 1;
  localparam longint TO_MAX  = (64'd1 << TO_W) - 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic bit ch_ok(int op, bit q, bit p);
    bit b;
    case (op & 7)
      0: b = (q == 0);
      1: b = (q == 1);
      2: b = 1;
      3: b = !p && q;
      4: b = p && !q;
      5: b = (p != q);
      6: b = (p == q);
      default: b = 0;
    endcase
    if ((op >> 3) == 0) return b;
    if ((op >> 3) == 1) return !b;
    return 1;
  endfunction

  function automatic bit stage_true(int s);
    int n = 0;
    for (int c = 0; c < CH; c++) n += ch_ok(m_op[s][c], m_dq[c], m_dp[c]);
    case (m_mode[s])
      0: return n == CH;
      1: return n > 0;
      2: return n != CH;
      default: return n == 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_stage = 0; m_hit = 0; m_to = 0; m_armprev = 1;
    m_dq = '0; m_dp = '0; p_fire = 0; p_tf = 0; m_last = 0; m_tov = 0;
    for (int s = 0; s < STAGES; s++) begin
      m_mode[s] = 0; m_cnt[s] = 0;
      for (int c = 0; c < CH; c++) m_op[s][c] = 0;
    end
  endtask

  task automatic model_step();
    bit fire = 0, tf = 0, c;
    longint need;
    if (m_state == 0) begin
      if (arm && !m_armprev) begin
        m_state = 1; m_stage = 0; m_hit = 0; m_to = 0;
        m_last = (int'(last_stage) > STAGES - 1) ? STAGES - 1 : int'(last_stage);
        m_tov  = int'(seq_timeout);
        for (int s = 0; s < STAGES; s++) begin
          m_mode[s] = int'(stage_mode[2*s +: 2]);
          m_cnt[s]  = longint'(stage_cnt[s*CNT_W +: CNT_W]);
          for (int ch = 0; ch < CH; ch++) m_op[s][ch] = int'(stage_op[(s*CH+ch)*6 +: 6]);
        end
      end
    end else if (m_state == 1) begin
      if (!arm) begin
        m_state = 0; m_stage = 0;
      end else if (trig_force) begin
        m_state = 2; fire = 1;
      end else begin
        c = stage_true(m_stage);
        need = (m_cnt[m_stage] == 0) ? 1 : m_cnt[m_stage];
        if (c && m_hit + 1 >= need) begin
          if (m_stage == m_last) begin
            m_state = 2; fire = 1;
          end else begin
            m_stage++; m_hit = 0; m_to = 0;
          end
        end else begin
          if (c && m_hit < HIT_MAX) m_hit++;
          if (m_stage != 0) begin
            if (m_tov != 0 && m_to == m_tov - 1) begin
              m_stage = 0; m_hit = 0; m_to = 0; tf = 1;
            end else if (m_to < TO_MAX) m_to++;
          end
        end
      end
    end else if (!arm) begin
      m_state = 0;
    end
    m_armprev = arm; m_dp = m_dq; m_dq = digital_in;
    p_fire = fire; p_tf = tf;
  endtask

  task automatic tick();
    bit e_trig, e_tev, e_armed, e_trd;
    int e_stage;
    @(posedge clk);
    if (!rstn) begin
      e_trig = 0; e_tev = 0; e_armed = 0; e_trd = 0; e_stage = 0;
      model_reset();
    end else begin
      e_trig = p_fire; e_tev = p_tf;
      e_armed = (m_state == 1); e_trd = (m_state == 2);
      e_stage = (m_state == 0) ? 0 : m_stage;
      model_step();
    end
    #1;
    chk("model_trig", 32'(trig), 32'(e_trig));
    chk("model_timeout_evt", 32'(timeout_evt), 32'(e_tev));
    chk("model_armed", 32'(armed), 32'(e_armed));
    chk("model_triggered", 32'(triggered), 32'(e_trd));
    chk("model_cur_stage", 32'(cur_stage), 32'(e_stage));
    trig_seen += int'(trig);
    to_seen += int'(timeout_evt);
  endtask

  task automatic set_op(input int s, input int c, input logic [5:0] op);
    stage_op[(s*CH+c)*6 +: 6] = op;
  endtask

  task automatic cfg_clear();
    for (int s = 0; s < STAGES; s++) begin
      for (int c = 0; c < CH; c++) set_op(s, c, 6'b000_010);
      stage_mode[2*s +: 2] = 2'b00;
      stage_cnt[s*CNT_W +: CNT_W] = CNT_W'(1);
    end
    last_stage = '0;
    seq_timeout = '0;
  endtask

  task automatic arm_cycle();
    arm = 0; tick();
    arm = 1; tick();
    tick();
  endtask

  task automatic async_reset(input int hold);
    rstn = 0;
    #1;
    chk("rst_trig", 32'(trig), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_triggered", 32'(triggered), 0);
    chk("rst_cur_stage", 32'(cur_stage), 0);
    chk("rst_timeout_evt", 32'(timeout_evt), 0);
    model_reset();
    repeat (hold) tick();
    rstn = 1;
  endtask

  function automatic logic [5:0] rand_op();
    if ($urandom_range(0, 9) < 6) return 6'b000_010;
    return {($urandom_range(0, 7) == 0) ? 3'b001 : (($urandom_range(0, 15) == 0) ? 3'b101 : 3'b000),
            3'($urandom_range(0, 7))};
  endfunction

  typedef struct {
    bit arm; logic [CH-1:0] din;
    bit t; bit a; bit tr; int st;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 0; arm = 0; trig_force = 0; digital_in = '0;
    stage_op = '0; stage_mode = '0; stage_cnt = '0;
    cfg_clear();
    model_reset();
    tick(); tick();
    rstn = 1;
    tick();

    // Single stage, rising edge on ch0
    cfg_clear();
    set_op(0, 0, 6'b000_011);
    tbl[0] = '{0, 8'h00, 0, 0, 0, 0};
    tbl[1] = '{1, 8'h00, 0, 0, 0, 0};
    tbl[2] = '{1, 8'h00, 0, 1, 0, 0};
    tbl[3] = '{1, 8'h01, 0, 1, 0, 0};
    tbl[4] = '{1, 8'h01, 0, 1, 0, 0};
    tbl[5] = '{1, 8'h01, 1, 0, 1, 0};
    tbl[6] = '{1, 8'h01, 0, 0, 1, 0};
    tbl[7] = '{0, 8'h01, 0, 0, 1, 0};
    tbl[8] = '{0, 8'h00, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      arm = tbl[i].arm; digital_in = tbl[i].din;
      tick();
      chk("tbl_trig", 32'(trig), 32'(tbl[i].t));
      chk("tbl_armed", 32'(armed), 32'(tbl[i].a));
      chk("tbl_triggered", 32'(triggered), 32'(tbl[i].tr));
      chk("tbl_cur_stage", 32'(cur_stage), 32'(tbl[i].st));
    end

    // Two stages: ch1 high x3, then ch2 fall
    cfg_clear();
    last_stage = SW'(1);
    set_op(0, 1, 6'b000_001); stage_cnt[0 +: CNT_W] = CNT_W'(3);
    set_op(1, 2, 6'b000_100);
    digital_in = 8'h04;
    arm_cycle();
    digital_in[1] = 1; tick(); tick();
    digital_in[1] = 0; repeat (3) tick();
    chk("s2_stage_hold", 32'(cur_stage), 0);
    arm_cycle();
    digital_in[1] = 1; repeat (3) tick();
    digital_in[1] = 0; repeat (2) tick();
    chk("s2_stage_adv", 32'(cur_stage), 1);
    trig_seen = 0;
    digital_in[2] = 0; repeat (5) tick();
    chk("s2_trig_count", 32'(trig_seen), 1);
    chk("s2_triggered", 32'(triggered), 1);

    // Stage-1 timeout, then fall on the last allowed cycle
    cfg_clear();
    last_stage = SW'(1);
    set_op(0, 0, 6'b000_001);
    set_op(1, 2, 6'b000_100);
    seq_timeout = TO_W'(5);
    digital_in = 8'h04;
    arm_cycle();
    trig_seen = 0; to_seen = 0;
    digital_in[0] = 1; tick();
    digital_in[0] = 0; repeat (9) tick();
    chk("s3_timeout_count", 32'(to_seen), 1);
    chk("s3_timeout_stage", 32'(cur_stage), 0);
    chk("s3_timeout_notrig", 32'(trig_seen), 0);
    arm_cycle();
    trig_seen = 0; to_seen = 0;
    digital_in[0] = 1; tick();
    digital_in[0] = 0; repeat (4) tick();
    digital_in[2] = 0; repeat (5) tick();
    chk("s3_edge_trig", 32'(trig_seen), 1);
    chk("s3_edge_notimeout", 32'(to_seen), 0);

    // Forced trigger cases
    cfg_clear();
    set_op(0, 0, 6'b000_001);
    digital_in = '0;
    arm_cycle();
    trig_seen = 0;
    trig_force = 1; tick(); trig_force = 0; repeat (4) tick();
    chk("s4_force_trig", 32'(trig_seen), 1);
    chk("s4_force_triggered", 32'(triggered), 1);
    arm = 0; tick(); tick();
    trig_seen = 0;
    trig_force = 1; tick(); trig_force = 0; repeat (4) tick();
    chk("s4_idle_force", 32'(trig_seen), 0);
    chk("s4_idle_triggered", 32'(triggered), 0);
    arm_cycle();
    trig_seen = 0;
    digital_in[0] = 1; tick();
    trig_force = 1; tick(); trig_force = 0; repeat (4) tick();
    chk("s4_force_and_match", 32'(trig_seen), 1);

    // Disarm on final match; config change while armed
    cfg_clear();
    set_op(0, 0, 6'b000_001);
    digital_in = '0;
    arm_cycle();
    trig_seen = 0;
    digital_in[0] = 1; tick();
    arm = 0; repeat (5) tick();
    chk("s5_disarm_trig", 32'(trig_seen), 0);
    chk("s5_disarm_armed", 32'(armed), 0);
    digital_in = '0;
    arm_cycle();
    set_op(0, 0, 6'b000_000);
    trig_seen = 0;
    repeat (5) tick();
    chk("s5_shadow_notrig", 32'(trig_seen), 0);
    chk("s5_shadow_armed", 32'(armed), 1);
    digital_in[0] = 1; repeat (4) tick();
    chk("s5_shadow_trig", 32'(trig_seen), 1);

    // Async reset in stage 1
    cfg_clear();
    last_stage = SW'(1);
    set_op(0, 0, 6'b000_001);
    set_op(1, 0, 6'b000_111);
    digital_in = '0;
    arm_cycle();
    digital_in[0] = 1; tick();
    digital_in[0] = 0; repeat (3) tick();
    chk("s6_in_stage1", 32'(cur_stage), 1);
    async_reset(2);
    trig_seen = 0;
    repeat (5) tick();
    chk("s6_post_rst_trig", 32'(trig_seen), 0);
    chk("s6_post_rst_armed", 32'(armed), 0);
    arm_cycle();
    chk("s6_rearm", 32'(armed), 1);

    // Random stimulus against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 0) begin
        last_stage = SW'($urandom_range(0, STAGES - 1));
        seq_timeout = TO_W'($urandom_range(0, 6));
        for (int s = 0; s < STAGES; s++) begin
          stage_mode[2*s +: 2] = 2'($urandom_range(0, 3));
          stage_cnt[s*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
          for (int c = 0; c < CH; c++) set_op(s, c, rand_op());
        end
      end
      if ($urandom_range(0, 29) == 0) arm = ~arm;
      trig_force = ($urandom_range(0, 79) == 0);
      digital_in = CH'($urandom);
      if (cyc == 1500) async_reset(2);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
